stage_head_scheduler: RTL and testbench

//  Sequencer for a 4-head LeViT stage: time-shares one attention-head datapath across NUM_HEADS heads per token.

---
 rtl/stage_head_scheduler_pkg.sv | 16 +
 rtl/stage_head_scheduler_watchdog.sv | 38 +++
 rtl/stage_head_scheduler.sv | 159 +++++++++++++++
 tb/tb_stage_head_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_head_scheduler_pkg.sv
// rtl/stage_head_scheduler_pkg.sv - shared state encoding and default sizes for the stage head scheduler
package stage_head_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_HEAD,
        S_MLP,
        S_FIN
    } sched_state_t;

    localparam int STAGE_HEADS   = 4;
    localparam int STAGE_TOKENS  = 16;
    localparam int SCHED_TIMEOUT = 1023;

endpackage

// File: rtl/stage_head_scheduler_watchdog.sv
// rtl/stage_head_scheduler_watchdog.sv - cycle watchdog that flags a stalled HEAD/MLP wait
//
// Ports:
//   clk    in  clock
//   rst    in  synchronous reset, active-high
//   clear  in  restart the count (state change)
//   enable in  count this cycle (waiting in HEAD or MLP)
//   expire out high in the TIMEOUT-th enabled cycle since the last clear
module sched_watchdog
    import stage_head_scheduler_pkg::*;
#(
    parameter int TIMEOUT = SCHED_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt;

    // The count holds at LAST; the FSM leaves the waiting state on expire,
    // so saturation only matters if the owner ignores the pulse.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/stage_head_scheduler.sv
// rtl/stage_head_scheduler.sv - per-token sequencer time-sharing one attention head datapath
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      run request (accepted only in IDLE)
//   abort      cancel the run, highest priority
//   head_done  attention datapath finished the current head (pulse)
//   mlp_done   MLP/residual path finished the token (pulse)
//   head_en    attention datapath enable (level)
//   head_sel   current head, also bias mux select
//   mlp_en     MLP/residual path enable (level)
//   acc_clr    clear the per-token head accumulator (pulse)
//   tok_idx    current token
//   busy       run in progress
//   done       all tokens completed (pulse)
//   err        sticky watchdog error, cleared by an accepted start
module stage_head_scheduler
    import stage_head_scheduler_pkg::*;
#(
    parameter int NUM_HEADS  = STAGE_HEADS,
    parameter int NUM_TOKENS = STAGE_TOKENS,
    parameter int TIMEOUT    = SCHED_TIMEOUT,
    parameter int HS_W       = $clog2(NUM_HEADS),
    parameter int TOK_W      = $clog2(NUM_TOKENS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             head_done,
    input  logic             mlp_done,
    output logic             head_en,
    output logic [HS_W-1:0]  head_sel,
    output logic             mlp_en,
    output logic             acc_clr,
    output logic [TOK_W-1:0] tok_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [HS_W-1:0]  HEAD_LAST = HS_W'(NUM_HEADS - 1);
    localparam logic [TOK_W-1:0] TOK_LAST  = TOK_W'(NUM_TOKENS - 1);

    sched_state_t state;
    sched_state_t next_state;

    logic             expire;
    logic             wd_enable;
    logic             wd_clear;

    logic             head_en_d;
    logic             mlp_en_d;
    logic             acc_clr_d;
    logic             busy_d;
    logic             done_d;
    logic             err_d;
    logic [HS_W-1:0]  head_sel_d;
    logic [TOK_W-1:0] tok_idx_d;

    assign wd_enable = (state == S_HEAD) || (state == S_MLP);
    // Any state change restarts the count, so each HEAD/MLP visit gets a full budget.
    assign wd_clear  = (next_state != state);

    sched_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (expire)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            head_en  <= 1'b0;
            mlp_en   <= 1'b0;
            acc_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            head_sel <= '0;
            tok_idx  <= '0;
        end else begin
            state    <= next_state;
            head_en  <= head_en_d;
            mlp_en   <= mlp_en_d;
            acc_clr  <= acc_clr_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            head_sel <= head_sel_d;
            tok_idx  <= tok_idx_d;
        end
    end

    // Next state: abort first, then watchdog, then the completion pulses.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) next_state = S_GAP;
            end
            S_GAP: begin
                next_state = abort ? S_IDLE : S_HEAD;
            end
            S_HEAD: begin
                if (abort || expire) begin
                    next_state = S_IDLE;
                end else if (head_done) begin
                    next_state = (head_sel == HEAD_LAST) ? S_MLP : S_GAP;
                end
            end
            S_MLP: begin
                if (abort || expire) begin
                    next_state = S_IDLE;
                end else if (mlp_done) begin
                    next_state = (tok_idx == TOK_LAST) ? S_FIN : S_GAP;
                end
            end
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output values for the next cycle, decoded from the transition being taken.
    always_comb begin
        head_en_d  = (next_state == S_HEAD);
        mlp_en_d   = (next_state == S_MLP);
        busy_d     = (next_state != S_IDLE);
        done_d     = (next_state == S_FIN);
        acc_clr_d  = 1'b0;
        err_d      = err;
        head_sel_d = head_sel;
        tok_idx_d  = tok_idx;

        if (state == S_IDLE && next_state == S_GAP) begin
            // New run: fresh indices, fresh accumulator, error history dropped.
            acc_clr_d  = 1'b1;
            err_d      = 1'b0;
            head_sel_d = '0;
            tok_idx_d  = '0;
        end else if (state == S_MLP && next_state == S_GAP) begin
            acc_clr_d  = 1'b1;
            head_sel_d = '0;
            tok_idx_d  = tok_idx + 1'b1;
        end else if (state == S_HEAD && next_state == S_GAP) begin
            head_sel_d = head_sel + 1'b1;
        end

        if (expire && !abort) err_d = 1'b1;
    end

endmodule

// File: tb/tb_stage_head_scheduler.sv
// tb/tb_stage_head_scheduler.sv - directed self-checking bench for stage_head_scheduler
module tb_stage_head_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       head_done = 1'b0;
    logic       mlp_done = 1'b0;
    logic       head_en;
    logic [1:0] head_sel;
    logic       mlp_en;
    logic       acc_clr;
    logic [0:0] tok_idx;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    stage_head_scheduler #(
        .NUM_HEADS  (4),
        .NUM_TOKENS (2),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .head_done (head_done),
        .mlp_done  (mlp_done),
        .head_en   (head_en),
        .head_sel  (head_sel),
        .mlp_en    (mlp_en),
        .acc_clr   (acc_clr),
        .tok_idx   (tok_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (acc_clr) acc_cnt++;
        if (done) done_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_head_done();
        head_done = 1'b1;
        cyc();
        head_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) cyc();
        checks++; if (head_en !== 1'b0) begin errors++; $display("FAIL reset_head_en got=%b exp=0", head_en); end
        checks++; if (head_sel !== 2'd0) begin errors++; $display("FAIL reset_head_sel got=%0d exp=0", head_sel); end
        checks++; if (mlp_en !== 1'b0) begin errors++; $display("FAIL reset_mlp_en got=%b exp=0", mlp_en); end
        checks++; if (acc_clr !== 1'b0) begin errors++; $display("FAIL reset_acc_clr got=%b exp=0", acc_clr); end
        checks++; if (tok_idx !== 1'b0) begin errors++; $display("FAIL reset_tok_idx got=%0d exp=0", tok_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        start = 1'b0;
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_full_run();
        int a0;
        int d0;
        a0 = acc_cnt;
        d0 = done_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got=%b exp=1", busy); end
        checks++; if (acc_clr !== 1'b1) begin errors++; $display("FAIL run_acc_clr_gap got=%b exp=1", acc_clr); end
        checks++; if (head_en !== 1'b0) begin errors++; $display("FAIL run_gap_head_en got=%b exp=0", head_en); end
        for (int t = 0; t < 2; t++) begin
            cyc();
            for (int h = 0; h < 4; h++) begin
                checks++; if (head_en !== 1'b1) begin errors++; $display("FAIL run_head_en t=%0d h=%0d got=%b exp=1", t, h, head_en); end
                checks++; if (head_sel !== 2'(h)) begin errors++; $display("FAIL run_head_sel t=%0d got=%0d exp=%0d", t, head_sel, h); end
                checks++; if (tok_idx !== 1'(t)) begin errors++; $display("FAIL run_tok_idx got=%0d exp=%0d", tok_idx, t); end
                repeat (4) cyc();
                pulse_head_done();
                if (h < 3) begin
                    checks++; if (head_en !== 1'b0 || acc_clr !== 1'b0) begin errors++; $display("FAIL run_head_gap h=%0d head_en=%b acc_clr=%b exp=0,0", h, head_en, acc_clr); end
                    cyc();
                end else begin
                    checks++; if (mlp_en !== 1'b1 || head_en !== 1'b0) begin errors++; $display("FAIL run_mlp_entry mlp_en=%b head_en=%b exp=1,0", mlp_en, head_en); end
                end
            end
            repeat (2) cyc();
            mlp_done = 1'b1;
            cyc();
            mlp_done = 1'b0;
            checks++; if (mlp_en !== 1'b0) begin errors++; $display("FAIL run_mlp_drop got=%b exp=0", mlp_en); end
            if (t == 0) begin
                checks++; if (acc_clr !== 1'b1) begin errors++; $display("FAIL run_acc_clr_tok got=%b exp=1", acc_clr); end
                checks++; if (tok_idx !== 1'b1) begin errors++; $display("FAIL run_tok_adv got=%0d exp=1", tok_idx); end
                checks++; if (head_sel !== 2'd0) begin errors++; $display("FAIL run_head_sel_rst got=%0d exp=0", head_sel); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_early_done got=%b exp=0", done); end
            end else begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done got=%b exp=1", done); end
            end
        end
        cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done_width got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_busy_end got=%b exp=0", busy); end
        checks++; if (tok_idx !== 1'b1 || head_sel !== 2'd3) begin errors++; $display("FAIL run_hold_idx tok=%0d head=%0d exp=1,3", tok_idx, head_sel); end
        cyc();
        checks++; if (acc_cnt - a0 !== 2) begin errors++; $display("FAIL run_acc_clr_count got=%0d exp=2", acc_cnt - a0); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL run_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || acc_clr !== 1'b0) begin errors++; $display("FAIL abort_start_idle busy=%b acc_clr=%b exp=0,0", busy, acc_clr); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        pulse_head_done();
        cyc();
        pulse_head_done();
        cyc();
        checks++; if (head_sel !== 2'd2 || head_en !== 1'b1) begin errors++; $display("FAIL abort_setup head_sel=%0d head_en=%b exp=2,1", head_sel, head_en); end
        head_done = 1'b1;
        abort = 1'b1;
        cyc();
        head_done = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (head_en !== 1'b0 || mlp_en !== 1'b0) begin errors++; $display("FAIL abort_enables head_en=%b mlp_en=%b exp=0,0", head_en, mlp_en); end
        checks++; if (head_sel !== 2'd2) begin errors++; $display("FAIL abort_head_sel got=%0d exp=2", head_sel); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err got=%b exp=0", err); end
        cyc();
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
    endtask

    task automatic test_watchdog();
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        repeat (7) cyc();
        checks++; if (head_en !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wd_before head_en=%b err=%b exp=1,0", head_en, err); end
        cyc();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wd_err got=%b exp=1", err); end
        checks++; if (busy !== 1'b0 || head_en !== 1'b0) begin errors++; $display("FAIL wd_idle busy=%b head_en=%b exp=0,0", busy, head_en); end
        cyc();
        checks++; if (err !== 1'b1 || done_cnt - d0 !== 0) begin errors++; $display("FAIL wd_sticky err=%b dones=%0d exp=1,0", err, done_cnt - d0); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wd_restart err=%b busy=%b exp=0,1", err, busy); end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    task automatic test_spurious();
        start = 1'b1;
        cyc();
        cyc();
        checks++; if (head_en !== 1'b1 || acc_clr !== 1'b0 || head_sel !== 2'd0) begin errors++; $display("FAIL sp_start_busy head_en=%b acc_clr=%b head_sel=%0d exp=1,0,0", head_en, acc_clr, head_sel); end
        mlp_done = 1'b1;
        cyc();
        mlp_done = 1'b0;
        start = 1'b0;
        checks++; if (head_en !== 1'b1 || mlp_en !== 1'b0 || tok_idx !== 1'b0 || head_sel !== 2'd0) begin errors++; $display("FAIL sp_mlp_in_head head_en=%b mlp_en=%b tok=%0d head=%0d exp=1,0,0,0", head_en, mlp_en, tok_idx, head_sel); end
        head_done = 1'b1;
        mlp_done = 1'b1;
        cyc();
        head_done = 1'b0;
        mlp_done = 1'b0;
        checks++; if (head_sel !== 2'd1 || head_en !== 1'b0 || mlp_en !== 1'b0) begin errors++; $display("FAIL sp_both_done head_sel=%0d head_en=%b mlp_en=%b exp=1,0,0", head_sel, head_en, mlp_en); end
        for (int h = 1; h < 4; h++) begin
            cyc();
            pulse_head_done();
        end
        checks++; if (mlp_en !== 1'b1) begin errors++; $display("FAIL sp_mlp_entry got=%b exp=1", mlp_en); end
        head_done = 1'b1;
        start = 1'b1;
        cyc();
        head_done = 1'b0;
        start = 1'b0;
        checks++; if (mlp_en !== 1'b1 || head_sel !== 2'd3 || tok_idx !== 1'b0 || acc_clr !== 1'b0) begin errors++; $display("FAIL sp_head_in_mlp mlp_en=%b head=%0d tok=%0d acc_clr=%b exp=1,3,0,0", mlp_en, head_sel, tok_idx, acc_clr); end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || mlp_en !== 1'b0) begin errors++; $display("FAIL sp_abort_mlp busy=%b mlp_en=%b exp=0,0", busy, mlp_en); end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            cyc();
            for (int h = 0; h < 4; h++) begin
                pulse_head_done();
                if (h < 3) cyc();
            end
            mlp_done = 1'b1;
            cyc();
            mlp_done = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || acc_clr !== 1'b1) begin errors++; $display("FAIL b2b_restart busy=%b acc_clr=%b exp=1,1", busy, acc_clr); end
        checks++; if (tok_idx !== 1'b0 || head_sel !== 2'd0) begin errors++; $display("FAIL b2b_indices tok=%0d head=%0d exp=0,0", tok_idx, head_sel); end
        cyc();
        checks++; if (head_en !== 1'b1) begin errors++; $display("FAIL b2b_head_en got=%b exp=1", head_en); end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_abort();
        test_watchdog();
        test_spurious();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
